// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side handshake bundle for the hazard/forwarding controller.
// master = decode/datapath side, slave = pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if;
  logic        validD;
  logic [3:0]  rs1D;
  logic [3:0]  rs2D;
  logic [3:0]  rdD;
  logic        reg_writeD;
  logic        mem_readD;
  logic        branchD;
  logic        takenD;
  logic        mem_busy;
  logic        stallF;
  logic        stallD;
  logic        bubbleE;
  logic        flushD;
  logic        stallE;
  logic        stallM;
  logic [1:0]  fwd1D;
  logic [1:0]  fwd2D;
  logic [1:0]  fwdAE;
  logic [1:0]  fwdBE;
  logic [15:0] stall_count;

  modport master (
    output validD, rs1D, rs2D, rdD,
    output reg_writeD, mem_readD,
    output branchD, takenD, mem_busy,
    input  stallF, stallD, bubbleE, flushD,
    input  stallE, stallM,
    input  fwd1D, fwd2D, fwdAE, fwdBE,
    input  stall_count
  );

  modport slave (
    input  validD, rs1D, rs2D, rdD,
    input  reg_writeD, mem_readD,
    input  branchD, takenD, mem_busy,
    output stallF, stallD, bubbleE, flushD,
    output stallE, stallM,
    output fwd1D, fwd2D, fwdAE, fwdBE,
    output stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: tracks E/M/W destinations, detects
// load-use and branch hazards, drives stall/bubble/flush/fwd selects.
// Ports: clk, reset (sync, active-high), hz (slave side of the bundle).
module pipeline_hazard_ctrl (
  input  logic clk,
  input  logic reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       rw;
    logic       ld;
  } ent_t;

  ent_t        e_q, m_q, w_q;
  ent_t        e_d, m_d, w_d;
  logic [15:0] cnt_q, cnt_d;

  logic freeze, run, lu, br, hazard;
  logic stall_o;

  function automatic logic hit(ent_t x, logic [3:0] a);
    return x.valid & x.rw & (x.rd == a);
  endfunction

  // Producer in M that is a load has no result yet; skip to W.
  function automatic logic [1:0] fsel(
    ent_t m, ent_t w, logic [3:0] a, logic en
  );
    logic [1:0] s;
    s = 2'b00;
    priority case (1'b1)
      !en:                    s = 2'b00;
      hit(m, a) && !m.ld:     s = 2'b01;
      hit(w, a):              s = 2'b10;
      default:                s = 2'b00;
    endcase
    return s;
  endfunction

  always_comb begin
    run    = ~reset;
    freeze = hz.mem_busy;
    lu = hz.validD & e_q.ld &
         (hit(e_q, hz.rs1D) | hit(e_q, hz.rs2D));
    br = hz.validD & hz.branchD &
         (hit(e_q, hz.rs1D) | hit(e_q, hz.rs2D) |
          (m_q.ld & (hit(m_q, hz.rs1D) |
                     hit(m_q, hz.rs2D))));
    hazard  = lu | br;
    stall_o = run & (freeze | hazard);

    hz.stallF  = stall_o;
    hz.stallD  = stall_o;
    hz.stallE  = run & freeze;
    hz.stallM  = run & freeze;
    hz.bubbleE = run & ~freeze & hazard;
    hz.flushD  = run & ~freeze & ~hazard &
                 hz.validD & hz.branchD & hz.takenD;

    hz.fwd1D = fsel(m_q, w_q, hz.rs1D, run & hz.validD);
    hz.fwd2D = fsel(m_q, w_q, hz.rs2D, run & hz.validD);
    hz.fwdAE = fsel(m_q, w_q, e_q.rs1, run & e_q.valid);
    hz.fwdBE = fsel(m_q, w_q, e_q.rs2, run & e_q.valid);
    hz.stall_count = run ? cnt_q : 16'h0000;
  end

  always_comb begin
    e_d = e_q;
    m_d = m_q;
    w_d = w_q;
    if (!freeze) begin
      w_d = m_q;
      m_d = e_q;
      if (hazard) e_d = '0;
      else begin
        e_d.valid = hz.validD;
        e_d.rd    = hz.rdD;
        e_d.rs1   = hz.rs1D;
        e_d.rs2   = hz.rs2D;
        e_d.rw    = hz.reg_writeD;
        e_d.ld    = hz.mem_readD;
      end
    end
    cnt_d = cnt_q;
    if (stall_o && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  // Source fields of M/W are kept for debug visibility only.
  logic unused_fields;
  assign unused_fields = ^{m_q.rs1, m_q.rs2,
                           w_q.rs1, w_q.rs2, w_q.ld};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: in-flight model plus
// directed hazard/forwarding/freeze/saturation vectors.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl dut (
    .clk(clk),
    .reset(reset),
    .hz(hz)
  );

  typedef struct {
    bit       v;
    bit [3:0] rd;
    bit [3:0] rs1;
    bit [3:0] rs2;
    bit       rw;
    bit       ld;
  } rec_t;

  // Instructions in flight, youngest first: [0]=E [1]=M [2]=W.
  rec_t pipe[$];
  int   cnt;
  int   total = 0;
  int   bad = 0;

  task automatic chk(string n, logic [15:0] a, logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int youngest(bit [3:0] a, int from);
    for (int k = from; k < 3; k++)
      if (pipe[k].v && pipe[k].rw && pipe[k].rd == a)
        return k;
    return 3;
  endfunction

  // when: 0 = read in D (branch), 1 = read in E (ALU).
  // Result is obtainable once the producer reaches W, or M if not a load.
  function automatic bit src_ok(bit [3:0] a, int when);
    int k;
    int pos;
    k = youngest(a, 0);
    if (k == 3) return 1'b1;
    pos = k + when;
    if (pos >= 2) return 1'b1;
    if (pos == 1) return !pipe[k].ld;
    return 1'b0;
  endfunction

  function automatic bit m_hazard();
    int w;
    if (!hz.validD) return 1'b0;
    w = hz.branchD ? 0 : 1;
    return !src_ok(hz.rs1D, w) || !src_ok(hz.rs2D, w);
  endfunction

  function automatic logic [1:0] m_fwd(bit [3:0] a);
    int k;
    k = youngest(a, 1);
    if (k == 1 && pipe[1].ld) k = youngest(a, 2);
    if (k == 1) return 2'b01;
    if (k == 2) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    rec_t r;
    bit   st;
    if (reset) begin
      r = '{default: 0};
      pipe = '{r, r, r};
      cnt = 0;
    end else begin
      st = m_hazard();
      if (hz.mem_busy) begin
        if (cnt < 65535) cnt++;
      end else begin
        if (st && cnt < 65535) cnt++;
        r = '{default: 0};
        if (!st) begin
          r.v   = hz.validD;
          r.rd  = hz.rdD;
          r.rs1 = hz.rs1D;
          r.rs2 = hz.rs2D;
          r.rw  = hz.reg_writeD;
          r.ld  = hz.mem_readD;
        end
        void'(pipe.pop_back());
        pipe.push_front(r);
      end
    end
  end

  always @(negedge clk) begin
    logic       h, fz, fl;
    logic [1:0] f1, f2, fa, fb;
    logic [15:0] c;
    if (reset) begin
      h = 0; fz = 0; fl = 0;
      f1 = 0; f2 = 0; fa = 0; fb = 0; c = 0;
    end else begin
      fz = hz.mem_busy;
      h  = m_hazard();
      fl = !fz && !h && hz.validD &&
           hz.branchD && hz.takenD;
      f1 = hz.validD ? m_fwd(hz.rs1D) : 2'b00;
      f2 = hz.validD ? m_fwd(hz.rs2D) : 2'b00;
      fa = pipe[0].v ? m_fwd(pipe[0].rs1) : 2'b00;
      fb = pipe[0].v ? m_fwd(pipe[0].rs2) : 2'b00;
      c  = 16'(cnt);
    end
    chk("stallF", 16'(hz.stallF), 16'(h | fz));
    chk("stallD", 16'(hz.stallD), 16'(h | fz));
    chk("stallE", 16'(hz.stallE), 16'(fz));
    chk("stallM", 16'(hz.stallM), 16'(fz));
    chk("bubbleE", 16'(hz.bubbleE), 16'(h & ~fz));
    chk("flushD", 16'(hz.flushD), 16'(fl));
    chk("fwd1D", 16'(hz.fwd1D), 16'(f1));
    chk("fwd2D", 16'(hz.fwd2D), 16'(f2));
    chk("fwdAE", 16'(hz.fwdAE), 16'(fa));
    chk("fwdBE", 16'(hz.fwdBE), 16'(fb));
    chk("count", hz.stall_count, c);
  end

  task automatic step(
    bit v, bit [3:0] r1, bit [3:0] r2, bit [3:0] rd,
    bit rw, bit ld, bit br, bit tk, bit busy
  );
    @(posedge clk);
    #1;
    hz.validD     = v;
    hz.rs1D       = r1;
    hz.rs2D       = r2;
    hz.rdD        = rd;
    hz.reg_writeD = rw;
    hz.mem_readD  = ld;
    hz.branchD    = br;
    hz.takenD     = tk;
    hz.mem_busy   = busy;
    #2;
  endtask

  task automatic nop(bit busy);
    step(0, 0, 0, 0, 0, 0, 0, 0, busy);
  endtask

  task automatic nops(int n);
    for (int i = 0; i < n; i++) nop(0);
  endtask

  initial begin
    hz.validD = 0; hz.rs1D = 0; hz.rs2D = 0;
    hz.rdD = 0; hz.reg_writeD = 0; hz.mem_readD = 0;
    hz.branchD = 0; hz.takenD = 0; hz.mem_busy = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #2;
    chk("lit_rst_cnt", hz.stall_count, 16'h0000);
    chk("lit_rst_stall", 16'(hz.stallF), 16'h0);

    // load-use on r3
    step(1, 1, 2, 3, 1, 1, 0, 0, 0);
    step(1, 3, 4, 6, 1, 0, 0, 0, 0);
    chk("lit_lu_stall", 16'(hz.stallF), 16'h1);
    chk("lit_lu_bub", 16'(hz.bubbleE), 16'h1);
    step(1, 3, 4, 6, 1, 0, 0, 0, 0);
    chk("lit_lu_go", 16'(hz.stallF), 16'h0);
    chk("lit_lu_bubfwd", 16'(hz.fwdAE), 16'h0);
    nop(0);
    chk("lit_lu_fwdW", 16'(hz.fwdAE), 16'h2);
    nops(3);

    // ALU r5 in M feeds taken branch
    step(1, 8, 9, 5, 1, 0, 0, 0, 0);
    nop(0);
    step(1, 5, 10, 0, 0, 0, 1, 1, 0);
    chk("lit_br_fwdM", 16'(hz.fwd1D), 16'h1);
    chk("lit_br_flush", 16'(hz.flushD), 16'h1);
    chk("lit_br_nostall", 16'(hz.stallF), 16'h0);
    nops(3);

    // branch after load r2: two stalls
    step(1, 1, 1, 2, 1, 1, 0, 0, 0);
    step(1, 2, 11, 0, 0, 0, 1, 1, 0);
    chk("lit_bl_st1", 16'(hz.stallF), 16'h1);
    chk("lit_bl_noflush", 16'(hz.flushD), 16'h0);
    step(1, 2, 11, 0, 0, 0, 1, 1, 0);
    chk("lit_bl_st2", 16'(hz.stallF), 16'h1);
    step(1, 2, 11, 0, 0, 0, 1, 1, 0);
    chk("lit_bl_go", 16'(hz.stallF), 16'h0);
    chk("lit_bl_fwdW", 16'(hz.fwd1D), 16'h2);
    chk("lit_bl_flush", 16'(hz.flushD), 16'h1);
    chk("lit_bl_cnt", hz.stall_count, 16'd3);
    nops(3);

    // r7 in both M and W, E reads r7
    step(1, 8, 9, 7, 1, 0, 0, 0, 0);
    step(1, 12, 13, 7, 1, 0, 0, 0, 0);
    step(1, 7, 14, 1, 1, 0, 0, 0, 0);
    nop(0);
    chk("lit_mprio", 16'(hz.fwdAE), 16'h1);
    chk("lit_mprio_b", 16'(hz.fwdBE), 16'h0);
    nops(3);

    // freeze over a load-use stall
    step(1, 1, 1, 3, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 3, 4, 6, 1, 0, 0, 0, 1);
      chk("lit_fz_stallM", 16'(hz.stallM), 16'h1);
      chk("lit_fz_bub", 16'(hz.bubbleE), 16'h0);
    end
    step(1, 3, 4, 6, 1, 0, 0, 0, 0);
    chk("lit_fz_resume", 16'(hz.bubbleE), 16'h1);
    step(1, 3, 4, 6, 1, 0, 0, 0, 0);
    chk("lit_fz_go", 16'(hz.stallF), 16'h0);
    chk("lit_fz_cnt", hz.stall_count, 16'd7);
    nops(3);

    // saturate the counter, then reset during freeze
    for (int i = 0; i < 65540; i++) nop(1);
    chk("lit_sat", hz.stall_count, 16'hFFFF);
    nop(1);
    chk("lit_sat_hold", hz.stall_count, 16'hFFFF);
    @(posedge clk);
    #1 reset = 1;
    #2;
    chk("lit_rstfz_st", 16'(hz.stallF), 16'h0);
    @(posedge clk);
    #1 reset = 0;
    hz.mem_busy = 0;
    #2;
    chk("lit_post_cnt", hz.stall_count, 16'h0000);
    chk("lit_post_stE", 16'(hz.stallE), 16'h0);
    nops(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
